// File: rtl/vdp_port_writer_if.sv
// rtl/vdp_port_writer_if.sv - command, write-stream, VDP I/O and read-result bundle for vdp_port_writer
interface vdp_port_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [13:0] cmd_addr;
    logic [2:0]  cmd_reg;
    logic [7:0]  cmd_data;
    logic [13:0] cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        io_wr;
    logic        io_rd;
    logic [7:0]  io_port;
    logic [7:0]  io_dout;
    logic [7:0]  io_din;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_type, cmd_addr, cmd_reg, cmd_data, cmd_len,
        input  wr_valid, wr_data, io_din,
        output cmd_ready, wr_ready, io_wr, io_rd, io_port, io_dout,
        output rd_valid, rd_data, busy
    );

    modport master (
        output cmd_valid, cmd_type, cmd_addr, cmd_reg, cmd_data, cmd_len,
        output wr_valid, wr_data, io_din,
        input  cmd_ready, wr_ready, io_wr, io_rd, io_port, io_dout,
        input  rd_valid, rd_data, busy
    );
endinterface

// File: rtl/vdp_port_writer.sv
// rtl/vdp_port_writer.sv - VDP control/data port sequencer with ce-paced accesses and inter-access gap
module vdp_port_writer #(
    parameter int unsigned GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    vdp_port_writer_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_CTRL0, S_CTRL1, S_DATA, S_GAP} state_t;

    localparam logic [3:0] GAP_W     = 4'(GAP);
    localparam logic [7:0] PORT_DATA = 8'hBE;
    localparam logic [7:0] PORT_CTRL = 8'hBF;

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;
    logic [1:0]  type_q, type_d;
    logic [13:0] addr_q, addr_d;
    logic [2:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic [13:0] rem_q, rem_d;
    logic [3:0]  gap_q, gap_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic        acc_wr;
    logic        acc_rd;
    logic        wr_rdy;
    logic [7:0]  port;
    logic [7:0]  dout;
    state_t      after_acc;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        type_d     = type_q;
        addr_d     = addr_q;
        reg_d      = reg_q;
        data_d     = data_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        acc_wr     = 1'b0;
        acc_rd     = 1'b0;
        wr_rdy     = 1'b0;
        port       = 8'h00;
        dout       = 8'h00;
        after_acc  = S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    type_d = bus.cmd_type;
                    addr_d = bus.cmd_addr;
                    reg_d  = bus.cmd_reg;
                    data_d = bus.cmd_data;
                    case (bus.cmd_type)
                        2'd0: begin
                            rem_d   = 14'd0;
                            state_d = S_CTRL0;
                        end
                        // Status read reuses DATA as a single read of the control port.
                        2'd3: begin
                            rem_d   = 14'd1;
                            state_d = S_DATA;
                        end
                        default: begin
                            rem_d   = bus.cmd_len;
                            state_d = S_CTRL0;
                        end
                    endcase
                end
            end
            S_CTRL0: begin
                if (ce) begin
                    acc_wr    = 1'b1;
                    port      = PORT_CTRL;
                    dout      = (type_q == 2'd0) ? data_q : addr_q[7:0];
                    after_acc = S_CTRL1;
                end
            end
            S_CTRL1: begin
                if (ce) begin
                    acc_wr = 1'b1;
                    port   = PORT_CTRL;
                    case (type_q)
                        2'd0:    dout = {1'b1, 4'b0000, reg_q};
                        2'd1:    dout = {2'b01, addr_q[13:8]};
                        default: dout = {2'b00, addr_q[13:8]};
                    endcase
                    after_acc = (rem_q == 14'd0) ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (ce) begin
                    if (type_q == 2'd1) begin
                        // A missing byte just stalls here; the gap already elapsed.
                        wr_rdy = 1'b1;
                        if (bus.wr_valid) begin
                            acc_wr = 1'b1;
                            port   = PORT_DATA;
                            dout   = bus.wr_data;
                        end
                    end else begin
                        acc_rd = 1'b1;
                        port   = (type_q == 2'd3) ? PORT_CTRL : PORT_DATA;
                    end
                    if (acc_wr || acc_rd) begin
                        rem_d     = rem_q - 14'd1;
                        after_acc = (rem_q == 14'd1) ? S_IDLE : S_DATA;
                    end
                end
            end
            S_GAP: begin
                if (ce) begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q <= 4'd1) begin
                        state_d = ret_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every access is followed by GAP idle ce cycles; with no gap go straight on.
        if (acc_wr || acc_rd) begin
            if (GAP_W == 4'd0) begin
                state_d = after_acc;
            end else begin
                state_d = S_GAP;
                ret_d   = after_acc;
                gap_d   = GAP_W;
            end
        end

        if (acc_rd) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.io_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            type_q     <= 2'd0;
            addr_q     <= 14'd0;
            reg_q      <= 3'd0;
            data_q     <= 8'h00;
            rem_q      <= 14'd0;
            gap_q      <= 4'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            gap_q      <= gap_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Strobes are combinational so they land in the ce cycle itself; reset suppresses them.
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.wr_ready  = wr_rdy && !reset;
    assign bus.io_wr     = acc_wr && !reset;
    assign bus.io_rd     = acc_rd && !reset;
    assign bus.io_port   = reset ? 8'h00 : port;
    assign bus.io_dout   = reset ? 8'h00 : dout;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: doc/vdp_port_writer.md
VDP_PORT_WRITER -- requirements
Module: vdp_port_writer

Interface
REQ-001 Parameter GAP, default 2, minimum number of ce-qualified idle cycles between consecutive bus accesses; legal range 0..15.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 ce  input  1  CPU-rate clock enable; bus accesses occur only on cycles with ce=1.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high while the block can accept a command (IDLE).
REQ-007 cmd_type  input  2  command: 0 = register write, 1 = VRAM write, 2 = VRAM read, 3 = status read.
REQ-008 cmd_addr  input  14  VRAM start address (types 1 and 2).
REQ-009 cmd_reg  input  3  VDP register number (type 0).
REQ-010 cmd_data  input  8  register value (type 0).
REQ-011 cmd_len  input  14  data-port transfer count (types 1 and 2); 0 means address setup only.
REQ-012 wr_valid / wr_ready  input / output  1 / 1  write-data stream handshake.
REQ-013 wr_data  input  8  VRAM write byte.
REQ-014 io_wr  output  1  one-cycle I/O write strobe.
REQ-015 io_rd  output  1  one-cycle I/O read strobe.
REQ-016 io_port  output  8  port address: 0xBE is data, 0xBF is control/status.
REQ-017 io_dout  output  8  byte written to the VDP.
REQ-018 io_din  input  8  VDP read data, valid in the same cycle as io_rd.
REQ-019 rd_valid / rd_data  output / output  1 / 8  read result; no backpressure.
REQ-020 busy  output  1  high whenever the block is not in IDLE.

Function
REQ-021 States: IDLE, CTRL0, CTRL1, DATA, GAP, with a registered return-state field.
- Accept on cmd_valid && cmd_ready; latch all cmd_* fields; move to CTRL0 (type 3 goes directly to DATA).
REQ-022 Access rules:
- Each access drives io_wr or io_rd high for exactly one clk cycle, and that cycle has ce=1.
- io_port and io_dout are valid in that cycle.
- At most one access per ce cycle.
- The first access occurs on the first ce=1 cycle strictly after the acceptance cycle.
REQ-023 Gap: after each access, enter GAP and wait GAP ce=1 cycles before the next access; GAP=0 allows accesses on consecutive ce cycles.
REQ-024 Type 0:
- CTRL0 writes cmd_data to 0xBF.
- CTRL1 writes {1'b1, 4'b0, cmd_reg} to 0xBF.
- Then return to IDLE.
REQ-025 Type 1:
- CTRL0 writes addr[7:0] to 0xBF.
- CTRL1 writes {2'b01, addr[13:8]} to 0xBF.
- DATA then performs cmd_len writes of wr_data to 0xBE.
REQ-026 Type 2: same control bytes as type 1 but second byte is {2'b00, addr[13:8]}; DATA then performs cmd_len reads of 0xBE.
REQ-027 Type 3: a single read of 0xBF.
REQ-028 Write-data consumption: wr_ready=1 only in the DATA-write access cycle, i.e. a ce=1 cycle while state is DATA.
- A byte is consumed when wr_valid && wr_ready.
- If wr_valid=0 on a ce cycle in DATA, no access occurs and the block stalls in DATA indefinitely; the gap does not restart.
REQ-029 Read results: rd_valid pulses for one cycle, one clk after each io_rd, with rd_data = io_din captured in the io_rd cycle.
REQ-030 Counter: remaining-count is 14 bits and decrements per data access.
- cmd_len=0 skips DATA and returns to IDLE after the CTRL1 gap.
- cmd_len=0x3FFF transfers 16383 bytes.
REQ-031 Completion: after the final access and its GAP, go to IDLE; cmd_ready rises in the cycle after the gap ends.
- A new command may be accepted in that same cycle.
REQ-032 cmd_valid while busy is ignored (not queued); latched fields do not change mid-command.
REQ-033 A ce pulse during IDLE or the acceptance cycle causes no access.

Reset
REQ-034 On reset=1 at a clk edge, including mid-command, the block SHALL enter IDLE and drive:
- io_wr=0, io_rd=0, io_port=0x00, io_dout=0x00
- rd_valid=0, rd_data=0x00, wr_ready=0, busy=0
- gap and remaining-count counters cleared
REQ-035 cmd_ready=1 on the first cycle after reset deasserts; any partially sent control-byte pair is abandoned, not completed.

Verification
REQ-036 Register write: type 0, reg=7, data=0xF4, ce every 7 clk, GAP=2 -> writes to 0xBF of 0xF4 then 0x87, separated by exactly 2 idle ce cycles; busy falls after the gap.
REQ-037 VRAM write: addr=0x3A55, len=3, stream 0x11,0x22,0x33, with wr_valid dropped for 10 ce cycles before byte 2 -> sequence 0x55@BF, 0x7A@BF, 0x11@BE, stall, 0x22@BE, 0x33@BE; exactly 3 handshakes.
REQ-038 VRAM read: addr=0x0100, len=2, io_din returns 0xAB then 0xCD -> control bytes 0x00, 0x01 to 0xBF; two io_rd pulses on 0xBE; rd_valid pulses carrying 0xAB then 0xCD, each one clk after its io_rd.
REQ-039 Edge cases: len=0 with type 1 -> only two control writes; GAP=0 -> accesses on consecutive ce cycles; type 3 -> single io_rd on 0xBF with rd_data=io_din.
REQ-040 Reset after the first control byte of a type 1 command -> no further strobes, cmd_ready=1 after reset; a subsequent type 0 command produces a correct two-byte sequence.
